player_health_ctrl: RTL and testbench
=====================================

// Module: player_health_ctrl
// PURPOSE
//  Per-player health bookkeeping; the producer side of the on-screen health bar.
//  Accepts hit events from the combat/collision logic and applies chip damage for blocked hits.
//  Enforces post-hit invulnerability and detects KO.
//  Drives the 5-bit curr_health consumed by the health bar renderer, which animates its own
//  displayed value down toward curr_health. One instance per player.
// PARAMETERS
//  FULL_HEALTH    31      health after reset/round_start; max value on curr_health (<=31)
//  INVULN_CYCLES  5000000 clk cycles of invulnerability after an unblocked damaging hit (>=1)
//  BLOCK_SHIFT    2       blocked-hit damage = hit_damage >> BLOCK_SHIFT
// PORTS
//  clk          in   1   system clock; one clock for the whole block
//  reset        in   1   synchronous, active-high reset
//  round_start  in   1   1-cycle pulse: restore full health, clear KO/invuln
//  hit_valid    in   1   hit event present this cycle
//  hit_damage   in   5   raw damage of the hit (0..31)
//  hit_blocked  in   1   defender was blocking; qualifies hit_valid
//  hit_ready    out  1   1 = block accepts a hit this cycle (combinational from state)
//  curr_health  out  5   current health; registered
//  hit_taken    out  1   1-cycle pulse, coincident with the curr_health update of an applied hit
//  invuln       out  1   1 while in INVULN state
//  ko           out  1   1 while in KO state
//  hit_count    out  8   number of applied hits since round start; saturates at 255
// BEHAVIOUR
//  Reset: reset=1 at a clk edge gives state=ALIVE, curr_health=FULL_HEALTH, hit_taken=0,
//   invuln=0, ko=0, hit_count=0, invuln counter=0.
//  round_start behaves identically to reset. It has priority over a hit in the same cycle;
//   that hit is dropped.
//  States:
//   - ALIVE: hit_ready=1.
//   - INVULN: hit_ready=0. Hits are ignored, not queued.
//   - KO: hit_ready=0. Terminal until reset/round_start.
//  Acceptance: a hit is accepted on a clk edge where hit_valid && hit_ready && !round_start.
//  Effective damage eff = hit_blocked ? (hit_damage >> BLOCK_SHIFT) : hit_damage.
//   Compute eff in 5 bits.
//  eff==0: accepted but a no-op. No health change, no hit_taken, no hit_count++,
//   state stays ALIVE.
//  eff>0 (latency 1): at the acceptance edge,
//   - curr_health <= sat_sub(curr_health, eff). Subtraction saturates at 0, no wrap.
//   - hit_taken <= 1 for exactly one cycle.
//   - hit_count <= hit_count + 1, saturating at 255.
//  Next state after an eff>0 hit:
//   - new health==0 -> KO. This applies to blocked hits too.
//   - else unblocked -> INVULN, with the counter loaded to INVULN_CYCLES-1.
//   - else (blocked) -> ALIVE; a block grants no invulnerability.
//  INVULN: the counter decrements once per cycle. At count==0 the next edge moves to ALIVE.
//   invuln is therefore high for exactly INVULN_CYCLES cycles.
//  A hit presented on the first ALIVE cycle after INVULN is accepted normally.
//  hit_valid held high continuously: one hit is applied per ALIVE cycle.
//   Each unblocked hit reopens an INVULN window.
//  curr_health never increases except via reset/round_start, and never exceeds FULL_HEALTH.
//  hit_damage >= curr_health (unblocked) goes to health 0 and KO in one step.
//  Reset or round_start mid-INVULN or in KO aborts immediately to the reset values.
//  All outputs except hit_ready are registered; there are no combinational paths from inputs
//   to outputs other than hit_ready.
// TESTING
//  1. Reset, then one unblocked hit, damage 7:
//     -> next cycle curr_health=24, hit_taken=1 for 1 cycle, invuln=1 for INVULN_CYCLES cycles.
//  2. Hit during INVULN (damage 10):
//     -> ignored, health unchanged, hit_count unchanged; a hit on the first ALIVE cycle applies.
//  3. Blocked hit, damage 9, BLOCK_SHIFT=2:
//     -> health 31->29, no invuln; blocked damage 3 -> eff=0, no-op, no hit_taken.
//  4. Health 4, unblocked damage 20:
//     -> curr_health=0 (no wrap), ko=1, hit_ready=0; later hits ignored.
//  5. round_start coincident with hit_valid (damage 5) while in KO:
//     -> next cycle health=31, ko=0, hit_count=0, hit dropped.
//  6. hit_valid held high, damage 1, unblocked, for 3*INVULN_CYCLES+3 cycles:
//     -> exactly 3 applied hits, health 28, hit_count=3.

Source files
------------

// File: rtl/player_health_ctrl.sv
// Per-player health bookkeeping: applies hit/chip damage, post-hit invulnerability and KO detection.
// Feeds the health bar renderer via a registered 5-bit curr_health.
module player_health_ctrl #(
  parameter int FULL_HEALTH   = 31,
  parameter int INVULN_CYCLES = 5000000,
  parameter int BLOCK_SHIFT   = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       round_start,
  input  logic       hit_valid,
  input  logic [4:0] hit_damage,
  input  logic       hit_blocked,
  output logic       hit_ready,
  output logic [4:0] curr_health,
  output logic       hit_taken,
  output logic       invuln,
  output logic       ko,
  output logic [7:0] hit_count
);

  localparam int CNT_W = (INVULN_CYCLES > 1) ? $clog2(INVULN_CYCLES) : 1;

  typedef enum logic [1:0] {ALIVE, INVULN, KO} state_t;

  state_t             state;
  logic [CNT_W-1:0]   inv_cnt;
  logic [4:0]         eff;
  logic [4:0]         new_health;

  assign hit_ready  = (state == ALIVE);
  assign eff        = hit_blocked ? (hit_damage >> BLOCK_SHIFT) : hit_damage;
  assign new_health = (curr_health > eff) ? (curr_health - eff) : 5'd0;

  always_ff @(posedge clk) begin
    if (reset || round_start) begin
      state       <= ALIVE;
      curr_health <= 5'(FULL_HEALTH);
      hit_taken   <= 1'b0;
      invuln      <= 1'b0;
      ko          <= 1'b0;
      hit_count   <= 8'd0;
      inv_cnt     <= '0;
    end else begin
      hit_taken <= 1'b0;
      case (state)
        ALIVE: begin
          // zero effective damage is accepted but leaves everything untouched
          if (hit_valid && (eff != 5'd0)) begin
            curr_health <= new_health;
            hit_taken   <= 1'b1;
            if (hit_count != 8'hff) hit_count <= hit_count + 8'd1;
            if (new_health == 5'd0) begin
              state <= KO;
              ko    <= 1'b1;
            end else if (!hit_blocked) begin
              state   <= INVULN;
              invuln  <= 1'b1;
              inv_cnt <= CNT_W'(INVULN_CYCLES - 1);
            end
          end
        end
        INVULN: begin
          if (inv_cnt == '0) begin
            state  <= ALIVE;
            invuln <= 1'b0;
          end else begin
            inv_cnt <= inv_cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_player_health_ctrl.sv
// Bench for player_health_ctrl: directed vector table, held-hit sequence, and randomized
// traffic checked against a cycle-level behavioural model.
module tb_player_health_ctrl;

  localparam int FULL = 31;
  localparam int INV  = 5;
  localparam int BSH  = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1, round_start = 1'b0, hit_valid = 1'b0, hit_blocked = 1'b0;
  logic [4:0] hit_damage = 5'd0;
  logic       hit_ready, hit_taken, invuln, ko;
  logic [4:0] curr_health;
  logic [7:0] hit_count;

  int checks = 0;
  int errors = 0;

  // behavioural model: health, remaining invulnerable cycles, KO flag, applied hit count
  int m_h = FULL, m_left = 0, m_ko = 0, m_cnt = 0, m_taken = 0;

  player_health_ctrl #(.FULL_HEALTH(FULL), .INVULN_CYCLES(INV), .BLOCK_SHIFT(BSH)) dut (
    .clk(clk), .reset(reset), .round_start(round_start), .hit_valid(hit_valid),
    .hit_damage(hit_damage), .hit_blocked(hit_blocked), .hit_ready(hit_ready),
    .curr_health(curr_health), .hit_taken(hit_taken), .invuln(invuln), .ko(ko),
    .hit_count(hit_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rst, rs, v;
    logic [4:0] d;
    logic b;
    int eh, et, ei, ek, ec;
  } vec_t;

  vec_t tbl[20];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int m_ready();
    return (m_ko == 0 && m_left == 0) ? 1 : 0;
  endfunction

  task automatic model_edge(input logic rst, rs, v, input logic [4:0] d, input logic b);
    int eff;
    eff = b ? (int'(d) >> BSH) : int'(d);
    m_taken = 0;
    if (rst || rs) begin
      m_h = FULL; m_left = 0; m_ko = 0; m_cnt = 0;
    end else if (m_ready() == 1 && v && eff > 0) begin
      m_h = (m_h > eff) ? m_h - eff : 0;
      m_taken = 1;
      m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
      if (m_h == 0) m_ko = 1;
      else if (!b) m_left = INV;
    end else if (m_left > 0) begin
      m_left--;
    end
  endtask

  task automatic step(input logic rst, rs, v, input logic [4:0] d, input logic b, input bit do_chk);
    reset = rst; round_start = rs; hit_valid = v; hit_damage = d; hit_blocked = b;
    if (do_chk) chk("ready_pre", hit_ready, m_ready());
    @(posedge clk);
    model_edge(rst, rs, v, d, b);
    #1;
    if (do_chk) begin
      chk("m_health", curr_health, m_h);
      chk("m_taken", hit_taken, m_taken);
      chk("m_invuln", invuln, (m_left > 0) ? 1 : 0);
      chk("m_ko", ko, m_ko);
      chk("m_count", hit_count, m_cnt);
      chk("m_ready", hit_ready, m_ready());
    end
  endtask

  initial begin
    int pulses;
    //            rst  rs   v    d      b    h   t  i  k  c
    tbl[0]  = '{1'b1,1'b0,1'b0,5'd0, 1'b0, 31, 0, 0, 0, 0};
    tbl[1]  = '{1'b0,1'b0,1'b1,5'd7, 1'b0, 24, 1, 1, 0, 1};
    tbl[2]  = '{1'b0,1'b0,1'b0,5'd0, 1'b0, 24, 0, 1, 0, 1};
    tbl[3]  = '{1'b0,1'b0,1'b1,5'd10,1'b0, 24, 0, 1, 0, 1};
    tbl[4]  = '{1'b0,1'b0,1'b0,5'd0, 1'b0, 24, 0, 1, 0, 1};
    tbl[5]  = '{1'b0,1'b0,1'b0,5'd0, 1'b0, 24, 0, 1, 0, 1};
    tbl[6]  = '{1'b0,1'b0,1'b1,5'd10,1'b0, 24, 0, 0, 0, 1};
    tbl[7]  = '{1'b0,1'b0,1'b1,5'd10,1'b0, 14, 1, 1, 0, 2};
    tbl[8]  = '{1'b0,1'b1,1'b0,5'd0, 1'b0, 31, 0, 0, 0, 0};
    tbl[9]  = '{1'b0,1'b0,1'b1,5'd9, 1'b1, 29, 1, 0, 0, 1};
    tbl[10] = '{1'b0,1'b0,1'b1,5'd3, 1'b1, 29, 0, 0, 0, 1};
    tbl[11] = '{1'b0,1'b0,1'b1,5'd31,1'b1, 22, 1, 0, 0, 2};
    tbl[12] = '{1'b0,1'b0,1'b1,5'd31,1'b1, 15, 1, 0, 0, 3};
    tbl[13] = '{1'b0,1'b0,1'b1,5'd31,1'b1,  8, 1, 0, 0, 4};
    tbl[14] = '{1'b0,1'b0,1'b1,5'd16,1'b1,  4, 1, 0, 0, 5};
    tbl[15] = '{1'b0,1'b0,1'b1,5'd20,1'b0,  0, 1, 0, 1, 6};
    tbl[16] = '{1'b0,1'b0,1'b1,5'd5, 1'b0,  0, 0, 0, 1, 6};
    tbl[17] = '{1'b0,1'b1,1'b1,5'd5, 1'b0, 31, 0, 0, 0, 0};
    tbl[18] = '{1'b0,1'b0,1'b1,5'd28,1'b0,  3, 1, 1, 0, 1};
    tbl[19] = '{1'b1,1'b0,1'b0,5'd0, 1'b0, 31, 0, 0, 0, 0};

    @(negedge clk);
    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].rs, tbl[i].v, tbl[i].d, tbl[i].b, 1'b0);
      chk($sformatf("v%0d_health", i), curr_health, tbl[i].eh);
      chk($sformatf("v%0d_taken", i), hit_taken, tbl[i].et);
      chk($sformatf("v%0d_invuln", i), invuln, tbl[i].ei);
      chk($sformatf("v%0d_ko", i), ko, tbl[i].ek);
      chk($sformatf("v%0d_count", i), hit_count, tbl[i].ec);
      chk($sformatf("v%0d_ready", i), hit_ready, (tbl[i].ei == 0 && tbl[i].ek == 0) ? 1 : 0);
    end

    // hit_valid held for 3*INV+3 cycles: one hit per ALIVE window
    step(1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
    pulses = 0;
    for (int i = 0; i < 3*INV+3; i++) begin
      step(1'b0, 1'b0, 1'b1, 5'd1, 1'b0, 1'b0);
      if (hit_taken) pulses++;
    end
    step(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    chk("hold_pulses", pulses, 3);
    chk("hold_health", curr_health, 28);
    chk("hold_count", hit_count, 3);

    // blocked hit that empties health still KOs
    step(1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, 5'd31, 1'b1, 1'b0);
    chk("blk_ko_health", curr_health, 0);
    chk("blk_ko", ko, 1);
    chk("blk_ko_invuln", invuln, 0);

    // randomized traffic against the model
    step(1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
    for (int i = 0; i < 600; i++) begin
      logic r_rst, r_rs, r_v, r_b;
      logic [4:0] r_d;
      r_rst = ($urandom_range(0, 79) == 0);
      r_rs  = ($urandom_range(0, 39) == 0);
      r_v   = ($urandom_range(0, 1) == 1);
      r_b   = ($urandom_range(0, 9) < 3);
      r_d   = 5'($urandom_range(0, 12));
      step(r_rst, r_rs, r_v, r_d, r_b, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
